// File: rtl/rv32i_loader_if.sv
// Byte-stream in / program-memory write out bundle for the RV32I boot loader.
// master = the loader's view, slave = the byte source and memory side.
interface rv32i_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        pm_we;
    logic [31:0] pm_addr;
    logic [31:0] pm_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output pm_we,
        output pm_addr,
        output pm_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  pm_we,
        input  pm_addr,
        input  pm_wdata
    );
endinterface

// File: rtl/rv32i_loader.sv
// Framed byte-stream boot loader: SYNC, 16-bit LE word count, LE instruction words,
// 8-bit additive checksum; releases the core only after a clean frame.
module rv32i_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    rv32i_loader_if.master    bus,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q,     state_d;
    logic [15:0]     len_q,       len_d;
    logic [1:0]      byte_idx_q,  byte_idx_d;
    logic [23:0]     asm_q,       asm_d;
    logic [7:0]      csum_q,      csum_d;
    logic [ADDR_W:0] wcnt_q,      wcnt_d;
    logic            pm_we_q,     pm_we_d;
    logic [31:0]     pm_addr_q,   pm_addr_d;
    logic [31:0]     pm_wdata_q,  pm_wdata_d;

    logic            rx_ready;
    logic            fire;
    logic [15:0]     len_full;
    logic            len_bad;
    logic            last_word;

    // Ready is a pure function of state so the source never sees a combinational loop.
    assign rx_ready  = (state_q == S_SYNC) || (state_q == S_LEN0) || (state_q == S_LEN1) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
    assign fire      = bus.rx_valid & rx_ready;
    assign len_full  = {bus.rx_data, len_q[7:0]};
    assign len_bad   = (len_full == 16'd0) || (32'(len_full) > 32'(MAX_WORDS));
    assign last_word = ((32'(wcnt_q) + 32'd1) == 32'(len_q));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        wcnt_d     = wcnt_q;
        pm_we_d    = 1'b0;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;

        if (fire) begin
            case (state_q)
                S_SYNC: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d = S_LEN0;
                    end
                end
                S_LEN0: begin
                    len_d   = {8'h00, bus.rx_data};
                    state_d = S_LEN1;
                end
                S_LEN1: begin
                    len_d      = len_full;
                    byte_idx_d = 2'd0;
                    wcnt_d     = '0;
                    asm_d      = '0;
                    csum_d     = 8'h00;
                    state_d    = len_bad ? S_ERR : S_DATA;
                end
                S_DATA: begin
                    csum_d     = csum_q + bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Shift in from the top: after three bytes asm_q holds {b2,b1,b0}.
                    asm_d      = {bus.rx_data, asm_q[23:8]};
                    if (byte_idx_q == 2'd3) begin
                        pm_we_d    = 1'b1;
                        pm_addr_d  = {{(30 - ADDR_W){1'b0}}, wcnt_q[ADDR_W-1:0], 2'b00};
                        pm_wdata_d = {bus.rx_data, asm_q};
                        wcnt_d     = wcnt_q + 1'b1;
                        if (last_word) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_SYNC;
            len_q      <= 16'd0;
            byte_idx_q <= 2'd0;
            asm_q      <= 24'd0;
            csum_q     <= 8'h00;
            wcnt_q     <= '0;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= 32'd0;
            pm_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            wcnt_q     <= wcnt_d;
            pm_we_q    <= pm_we_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.pm_we    = pm_we_q;
    assign bus.pm_addr  = pm_addr_q;
    assign bus.pm_wdata = pm_wdata_q;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign core_rst_n   = (state_q == S_DONE);
    assign words_loaded = wcnt_q;
endmodule

// File: tb/tb_rv32i_loader.sv
// Scoreboard bench for rv32i_loader: expected writes are queued as 4th bytes are driven
// and popped by a monitor that samples the write port on the falling edge.
module tb_rv32i_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;

    rv32i_loader_if bus ();
    rv32i_loader_if bus1 ();

    logic        core_rst_n, done, error;
    logic [10:0] words_loaded;
    logic        core_rst_n1, done1, error1;
    logic [2:0]  words_loaded1;

    rv32i_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    rv32i_loader #(.ADDR_W(2), .SYNC_BYTE(8'hA5)) dut_small (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus1),
        .core_rst_n   (core_rst_n1),
        .done         (done1),
        .error        (error1),
        .words_loaded (words_loaded1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic        fire_prev = 1'b0;
    logic [31:0] img [2] = '{32'h0000_0013, 32'h0010_0093};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) fire_prev <= reset && bus.rx_valid && bus.rx_ready;

    always @(negedge clk) begin
        if (bus.pm_we === 1'b1) begin
            logic [63:0] e;
            check("we_after_xfer", fire_prev, 1);
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pm_addr", bus.pm_addr, e[63:32]);
                check("pm_wdata", bus.pm_wdata, e[31:0]);
            end
        end
        if (bus1.pm_we === 1'b1) check("small_we", bus1.pm_we, 0);
    end

    task automatic send(input logic [7:0] b, input bit rnd);
        if (rnd) begin
            repeat ($urandom_range(0, 3)) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        bus1.rx_valid = 1'b1;
        bus1.rx_data  = b;
        @(posedge clk); #1;
        bus1.rx_valid = 1'b0;
    endtask

    // Frame: leading junk, sync, N=2, up to ndata data bytes, then checksum + csum_adj.
    task automatic send_frame(input bit rnd, input logic [7:0] csum_adj, input int ndata);
        logic [7:0] sum = 8'h00;
        logic [31:0] w;
        logic [7:0] b;
        send(8'h00, rnd);
        send(8'hA5, rnd);
        send(8'h02, rnd);
        send(8'h00, rnd);
        for (int i = 0; i < ndata; i++) begin
            w = img[i/4];
            b = w[8*(i%4) +: 8];
            sum = sum + b;
            if (i % 4 == 3) exp_q.push_back({32'(4 * (i / 4)), w});
            send(b, rnd);
        end
        if (ndata == 8) send(sum + csum_adj, rnd);
    endtask

    task automatic do_reset(input bit with_byte);
        reset = 1'b0;
        bus.rx_valid = with_byte;
        bus.rx_data  = 8'hA5;
        @(posedge clk); #1;
        check("rst_pm_we", bus.pm_we, 0);
        check("rst_wl", words_loaded, 0);
        check("rst_ready", bus.rx_ready, 1);
        check("rst_flags", {done, error, core_rst_n}, 3'b000);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, {done, error, core_rst_n}, 3'b101);
        check({tag, "_wl"}, words_loaded, 2);
        check({tag, "_ready"}, bus.rx_ready, 0);
        check({tag, "_sb"}, exp_q.size(), 0);
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus1.rx_valid = 1'b0;
        bus1.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("init_ready", bus.rx_ready, 1);
        check("init_we", bus.pm_we, 0);
        check("init_addr", bus.pm_addr, 0);
        check("init_wdata", bus.pm_wdata, 0);
        check("init_flags", {done, error, core_rst_n}, 3'b000);
        check("init_wl", words_loaded, 0);
        reset = 1'b1;

        // Clean frame, then traffic after completion must be ignored.
        send_frame(1'b0, 8'h00, 8);
        @(posedge clk); #1;
        check_done("clean");
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        @(posedge clk); #1;
        check_done("post_done");

        // Bad checksum: both words still written, frame rejected.
        do_reset(1'b0);
        send_frame(1'b0, 8'h02, 8);
        @(posedge clk); #1;
        check("badcs_flags", {done, error, core_rst_n}, 3'b010);
        check("badcs_wl", words_loaded, 2);
        check("badcs_ready", bus.rx_ready, 0);
        check("badcs_sb", exp_q.size(), 0);

        // Zero length.
        do_reset(1'b0);
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        check("len0_wait", error, 0);
        send(8'h00, 1'b0);
        check("len0_err", {done, error, core_rst_n}, 3'b010);
        check("len0_wl", words_loaded, 0);

        // Small instance: N = MAX_WORDS+1 rejected, N = MAX_WORDS accepted.
        send1(8'hA5);
        send1(8'h05);
        send1(8'h00);
        check("small_over", {done1, error1, core_rst_n1}, 3'b010);
        do_reset(1'b0);
        send1(8'hA5);
        send1(8'h04);
        send1(8'h00);
        check("small_max_err", error1, 0);
        check("small_max_ready", bus1.rx_ready, 1);

        // Random stalls on rx_valid.
        do_reset(1'b0);
        send_frame(1'b1, 8'h00, 8);
        repeat (2) @(posedge clk);
        #1;
        check_done("rnd");

        // Abort mid-frame with a byte offered during the reset edge.
        do_reset(1'b0);
        send_frame(1'b0, 8'h00, 6);
        @(posedge clk); #1;
        check("abort_wl", words_loaded, 1);
        do_reset(1'b1);
        send_frame(1'b0, 8'h00, 8);
        @(posedge clk); #1;
        check_done("restart");

        repeat (3) @(posedge clk);
        #1;
        check("final_sb", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
